// File: rtl/fb_rect_painter.sv
// fb_rect_painter: optionally clears the frame buffer to a background colour,
// then fills a screen-clipped rectangle, one word per cycle, raster order.
//
// Handshake: start is accepted only in IDLE and all command fields are latched
// on that edge. busy is high from the first cycle after acceptance until the
// cycle before done; done is a single-cycle pulse with busy low. The write
// port has no back-pressure: wr_en high means one word is written that cycle.
module fb_rect_painter #(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int ADDR_W    = 15,
  parameter int COLOR_W   = 24,
  parameter int X_W       = 8,
  parameter int Y_W       = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clear_en,
  input  logic [X_W-1:0]     rect_x,
  input  logic [Y_W-1:0]     rect_y,
  input  logic [X_W-1:0]     rect_w,
  input  logic [Y_W-1:0]     rect_h,
  input  logic [COLOR_W-1:0] rect_color,
  input  logic [COLOR_W-1:0] bg_color,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               wr_en
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SETUP = 3'd2,
    S_DRAW  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int                N         = FB_WIDTH * FB_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(FB_WIDTH);
  localparam logic [X_W:0]      X_LIM     = (X_W+1)'(FB_WIDTH);
  localparam logic [Y_W:0]      Y_LIM     = (Y_W+1)'(FB_HEIGHT);

  // Registered state and outputs
  state_t               r_state;
  logic                 r_busy, r_done, r_wr_en;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [COLOR_W-1:0]   r_wr_data;

  // Latched command
  logic [X_W-1:0]       r_rect_x, r_rect_w;
  logic [Y_W-1:0]       r_rect_y, r_rect_h;
  logic [COLOR_W-1:0]   r_color, r_bg;

  // Raster walk: current pixel, last column/row, base address of current row
  logic [X_W-1:0]       r_x, r_x_last;
  logic [Y_W-1:0]       r_y, r_y_last;
  logic [ADDR_W-1:0]    r_row_base;

  // Next-state values
  state_t               w_state_nxt;
  logic                 w_busy_nxt, w_done_nxt, w_wr_en_nxt;
  logic [ADDR_W-1:0]    w_wr_addr_nxt, w_row_base_nxt;
  logic [COLOR_W-1:0]   w_wr_data_nxt, w_color_nxt, w_bg_nxt;
  logic [X_W-1:0]       w_rect_x_nxt, w_rect_w_nxt, w_x_nxt, w_x_last_nxt;
  logic [Y_W-1:0]       w_rect_y_nxt, w_rect_h_nxt, w_y_nxt, w_y_last_nxt;

  // Clipped bounds; sums are one bit wider so large w/h cannot wrap
  logic [X_W:0]         w_x_sum, w_x_end;
  logic [Y_W:0]         w_y_sum, w_y_end;
  logic                 w_empty;
  logic [ADDR_W-1:0]    w_row0;

  // Clip the latched rectangle against the screen edges
  always_comb begin
    w_x_sum = {1'b0, r_rect_x} + {1'b0, r_rect_w};
    w_y_sum = {1'b0, r_rect_y} + {1'b0, r_rect_h};
    w_x_end = (w_x_sum > X_LIM) ? X_LIM : w_x_sum;
    w_y_end = (w_y_sum > Y_LIM) ? Y_LIM : w_y_sum;
    // Covers w=0, h=0 and origins at or beyond the right/bottom edge
    w_empty = (w_x_end <= {1'b0, r_rect_x}) || (w_y_end <= {1'b0, r_rect_y});
    // Constant multiply, evaluated once per command in SETUP (shift-add)
    w_row0  = ADDR_W'(r_rect_y) * ROW_STEP;
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_en_nxt    = 1'b0;
    w_wr_addr_nxt  = '0;
    w_wr_data_nxt  = '0;
    w_rect_x_nxt   = r_rect_x;
    w_rect_y_nxt   = r_rect_y;
    w_rect_w_nxt   = r_rect_w;
    w_rect_h_nxt   = r_rect_h;
    w_color_nxt    = r_color;
    w_bg_nxt       = r_bg;
    w_x_nxt        = r_x;
    w_y_nxt        = r_y;
    w_x_last_nxt   = r_x_last;
    w_y_last_nxt   = r_y_last;
    w_row_base_nxt = r_row_base;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_rect_x_nxt = rect_x;
          w_rect_y_nxt = rect_y;
          w_rect_w_nxt = rect_w;
          w_rect_h_nxt = rect_h;
          w_color_nxt  = rect_color;
          w_bg_nxt     = bg_color;
          if (clear_en) begin
            // First clear word goes out in the very next cycle
            w_state_nxt   = S_CLEAR;
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = '0;
            w_wr_data_nxt = bg_color;
          end else begin
            w_state_nxt = S_SETUP;
          end
        end
      end

      S_CLEAR: begin
        if (r_wr_addr == LAST_ADDR) begin
          w_state_nxt = S_SETUP;
        end else begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_wr_addr + ADDR_W'(1);
          w_wr_data_nxt = r_bg;
        end
      end

      S_SETUP: begin
        if (w_empty) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt    = S_DRAW;
          w_wr_en_nxt    = 1'b1;
          w_wr_addr_nxt  = w_row0 + ADDR_W'(r_rect_x);
          w_wr_data_nxt  = r_color;
          w_x_nxt        = r_rect_x;
          w_y_nxt        = r_rect_y;
          w_x_last_nxt   = w_x_end[X_W-1:0] - X_W'(1);
          w_y_last_nxt   = w_y_end[Y_W-1:0] - Y_W'(1);
          w_row_base_nxt = w_row0;
        end
      end

      S_DRAW: begin
        if (r_x == r_x_last) begin
          if (r_y == r_y_last) begin
            w_state_nxt = S_DONE;
          end else begin
            // Wrap to the left column of the next row
            w_wr_en_nxt    = 1'b1;
            w_x_nxt        = r_rect_x;
            w_y_nxt        = r_y + Y_W'(1);
            w_row_base_nxt = r_row_base + ROW_STEP;
            w_wr_addr_nxt  = r_row_base + ROW_STEP + ADDR_W'(r_rect_x);
            w_wr_data_nxt  = r_color;
          end
        end else begin
          w_wr_en_nxt   = 1'b1;
          w_x_nxt       = r_x + X_W'(1);
          w_wr_addr_nxt = r_wr_addr + ADDR_W'(1);
          w_wr_data_nxt = r_color;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_CLEAR) || (w_state_nxt == S_SETUP) ||
                 (w_state_nxt == S_DRAW);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // State, output and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_rect_x   <= '0;
      r_rect_y   <= '0;
      r_rect_w   <= '0;
      r_rect_h   <= '0;
      r_color    <= '0;
      r_bg       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_x_last   <= '0;
      r_y_last   <= '0;
      r_row_base <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_rect_x   <= w_rect_x_nxt;
      r_rect_y   <= w_rect_y_nxt;
      r_rect_w   <= w_rect_w_nxt;
      r_rect_h   <= w_rect_h_nxt;
      r_color    <= w_color_nxt;
      r_bg       <= w_bg_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_x_last   <= w_x_last_nxt;
      r_y_last   <= w_y_last_nxt;
      r_row_base <= w_row_base_nxt;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule
